// File: rtl/ipv4_head_tx_stream.sv
// IPv4 header generator: computes the RFC 791 header checksum over ten 16-bit words,
// then streams the 20-byte header as DATA_W-bit beats with the first wire byte in the low lane.
module ipv4_head_tx_stream #(
  parameter int          DATA_W   = 16,
  parameter int          LEN_W    = 16,
  parameter logic [31:0] SRC_ADDR = 32'hCEC87F80,
  parameter logic [31:0] DST_ADDR = 32'hCEC87F80,
  parameter logic [5:0]  DSCP     = 6'h2e,
  parameter logic [1:0]  ECN      = 2'b00,
  parameter logic [7:0]  TTL      = 8'd64,
  parameter logic [7:0]  PROTOCOL = 8'd17,
  parameter logic [15:0] ID_INIT  = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_v_i,
  input  logic [LEN_W-1:0]  data_len_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              head_v_o,
  output logic [DATA_W-1:0] head_o,
  output logic              head_last_o,
  input  logic              head_ready_i
);
  localparam int HEAD_BEATS = 160 / DATA_W;
  localparam int BW         = $clog2(HEAD_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(HEAD_BEATS - 1);

  typedef enum logic [1:0] {IDLE, CSUM, FOLD, SEND} state_t;

  state_t              state_q;
  logic [15:0]         tot_q, id_q, idc_q, ck_q;
  logic [19:0]         acc_q;
  logic [3:0]          widx_q;
  logic [BW-1:0]       beat_q;
  logic                head_v_q, last_q, busy_q, err_q;
  logic [DATA_W-1:0]   head_q;

  // Byte k of the header sits at bits [8k +: 8], so beat b is simply bits [b*DATA_W +: DATA_W].
  function automatic logic [159:0] hdr_vec(input logic [15:0] tl, input logic [15:0] id,
                                           input logic [15:0] ck);
    logic [159:0] v;
    v          = '0;
    v[7:0]     = 8'h45;
    v[15:8]    = {DSCP, ECN};
    v[23:16]   = tl[15:8];
    v[31:24]   = tl[7:0];
    v[39:32]   = id[15:8];
    v[47:40]   = id[7:0];
    v[55:48]   = 8'h40;
    v[63:56]   = 8'h00;
    v[71:64]   = TTL;
    v[79:72]   = PROTOCOL;
    v[87:80]   = ck[15:8];
    v[95:88]   = ck[7:0];
    for (int i = 0; i < 4; i++) begin
      v[96 + 8*i +: 8]  = SRC_ADDR[31 - 8*i -: 8];
      v[128 + 8*i +: 8] = DST_ADDR[31 - 8*i -: 8];
    end
    return v;
  endfunction

  logic [15:0]   ck_sel, ck_c, word_c, tot_c;
  logic [16:0]   s1_c, s2_c;
  logic [159:0]  hdr_c;
  logic [BW-1:0] nbeat_c;
  logic          too_big_c;

  always_comb begin
    s1_c      = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
    s2_c      = {1'b0, s1_c[15:0]} + {16'b0, s1_c[16]};
    ck_c      = ~s2_c[15:0];
    ck_sel    = 16'h0;
    if (state_q == FOLD) ck_sel = ck_c;
    else if (state_q == SEND) ck_sel = ck_q;
    hdr_c     = hdr_vec(tot_q, id_q, ck_sel);
    word_c    = {hdr_c[int'(widx_q)*16 +: 8], hdr_c[int'(widx_q)*16 + 8 +: 8]};
    nbeat_c   = beat_q + 1'b1;
    too_big_c = 32'(data_len_i) > 32'd65515;
    tot_c     = 16'(32'(data_len_i) + 32'd20);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tot_q    <= '0;
      id_q     <= '0;
      idc_q    <= ID_INIT;
      ck_q     <= '0;
      acc_q    <= '0;
      widx_q   <= '0;
      beat_q   <= '0;
      head_v_q <= 1'b0;
      head_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (start_v_i) begin
          if (too_big_c) err_q <= 1'b1;
          else begin
            tot_q   <= tot_c;
            id_q    <= idc_q;
            acc_q   <= '0;
            widx_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CSUM;
          end
        end
        CSUM: begin
          acc_q  <= acc_q + {4'b0, word_c};
          widx_q <= widx_q + 4'd1;
          if (widx_q == 4'd9) state_q <= FOLD;
        end
        FOLD: begin
          ck_q     <= ck_c;
          beat_q   <= '0;
          head_q   <= hdr_c[DATA_W-1:0];
          head_v_q <= 1'b1;
          last_q   <= (HEAD_BEATS == 1);
          state_q  <= SEND;
        end
        SEND: if (head_ready_i) begin
          if (beat_q == LAST_BEAT) begin
            head_v_q <= 1'b0;
            last_q   <= 1'b0;
            head_q   <= '0;
            busy_q   <= 1'b0;
            idc_q    <= idc_q + 16'd1;
            state_q  <= IDLE;
          end else begin
            beat_q <= nbeat_c;
            head_q <= hdr_c[int'(nbeat_c)*DATA_W +: DATA_W];
            last_q <= (nbeat_c == LAST_BEAT);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign head_v_o    = head_v_q;
  assign head_o      = head_q;
  assign head_last_o = last_q;
endmodule
